// File: rtl/cpu_run_pkg.sv
// Shared types and reset values for the CPU run-state controller.
// Imported by clk_en_divider and cpu_run_ctrl.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SLEEP = 2'd1,
        HALT  = 2'd2
    } run_state_t;

    localparam run_state_t RST_STATE  = RUN;
    localparam logic       RST_CLK_EN = 1'b1;

endpackage

// File: rtl/cpu_run_ctrl_clk_en_divider.sv
// Free-running divider producing the pipeline stage enable pulse.
// clk_en is high one clk out of every (clock_divider + 1).
module clk_en_divider
    import cpu_run_pkg::*;
#(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clock_divider,
    output logic             clk_en
);

    logic [DIV_W-1:0] cnt;

    // Unsigned >= so that lowering clock_divider below cnt ends the period at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            clk_en <= RST_CLK_EN;
        end else if (cnt >= clock_divider) begin
            cnt    <= '0;
            clk_en <= 1'b1;
        end else begin
            cnt    <= cnt + DIV_W'(1);
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-state controller: RUN/SLEEP/HALT, pipeline freeze, sleep-PC capture, wake tracking.
// Optional sleep self-wake timer enabled by defining CPU_RUN_CTRL_WAKE_TMR_EN.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 16,
    parameter int unsigned DIV_W      = 32,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned WAKE_TMR_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_W-1:0]      clock_divider,
    output logic                  clk_en,
    input  logic [NUM_IRQ-1:0]    irq_state,
    input  logic [NUM_IRQ-1:0]    wake_mask,
    input  logic                  exec_sleep,
    input  logic [PC_W-1:0]       exec_sleep_pc,
    input  logic                  wb_halt,
    input  logic                  irq_taken,
    input  logic [WAKE_TMR_W-1:0] sleep_timeout,
    output logic                  stall_pipe,
    output logic                  halted,
    output logic                  sleeping,
    output logic [PC_W-1:0]       sleep_pc,
    output logic                  wake_pending,
    output logic                  wake_timeout
);

    run_state_t      state, state_n;
    logic [PC_W-1:0] sleep_pc_n;
    logic            wake_pending_n;
    logic            wake;
    logic            irq_wake;

    clk_en_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk          (clk),
        .rst          (rst),
        .clock_divider(clock_divider),
        .clk_en       (clk_en)
    );

    assign wake = |(irq_state & wake_mask);

`ifdef CPU_RUN_CTRL_WAKE_TMR_EN
    logic [WAKE_TMR_W-1:0] tmr, tmr_n;
    logic                  wake_timeout_n;
`else
    logic unused_sleep_timeout;
    assign unused_sleep_timeout = ^sleep_timeout;
    assign wake_timeout         = 1'b0;
`endif

    always_comb begin
        state_n        = state;
        sleep_pc_n     = sleep_pc;
        wake_pending_n = wake_pending;
        irq_wake       = 1'b0;
`ifdef CPU_RUN_CTRL_WAKE_TMR_EN
        tmr_n          = tmr;
        wake_timeout_n = wake_timeout;
`endif
        if (clk_en) begin
`ifdef CPU_RUN_CTRL_WAKE_TMR_EN
            wake_timeout_n = 1'b0;
`endif
            unique case (state)
                RUN: begin
                    if (wb_halt) begin
                        state_n = HALT;
                    end else if (exec_sleep) begin
                        state_n    = SLEEP;
                        sleep_pc_n = exec_sleep_pc;
`ifdef CPU_RUN_CTRL_WAKE_TMR_EN
                        tmr_n      = sleep_timeout;
`endif
                    end
                end
                SLEEP: begin
                    // An irq wake in the same enable as the timer expiring takes precedence.
                    if (wake) begin
                        state_n  = RUN;
                        irq_wake = 1'b1;
                    end
`ifdef CPU_RUN_CTRL_WAKE_TMR_EN
                    else if (tmr != '0) begin
                        tmr_n = tmr - WAKE_TMR_W'(1);
                        if (tmr == WAKE_TMR_W'(1)) begin
                            state_n        = RUN;
                            wake_timeout_n = 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase

            if (irq_taken) begin
                wake_pending_n = 1'b0;
            end else if (irq_wake) begin
                wake_pending_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RST_STATE;
            sleep_pc     <= '0;
            wake_pending <= 1'b0;
        end else begin
            state        <= state_n;
            sleep_pc     <= sleep_pc_n;
            wake_pending <= wake_pending_n;
        end
    end

`ifdef CPU_RUN_CTRL_WAKE_TMR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr          <= '0;
            wake_timeout <= 1'b0;
        end else begin
            tmr          <= tmr_n;
            wake_timeout <= wake_timeout_n;
        end
    end
`endif

    assign sleeping   = (state == SLEEP);
    assign halted     = (state == HALT);
    assign stall_pipe = (state != RUN);

endmodule
